// File: rtl/mmu_ram_seq.sv
// ============================================================================
// mmu_ram_seq
// ----------------------------------------------------------------------------
// Sequencer in front of the external 256x8 MMU mapping RAM.
//
// After reset it walks all 256 entries and writes the default identity map,
// holding the CPU halted (nHALT low) until the walk finishes. After that the
// mmu block's RAM port passes straight through to the physical RAM with no
// added latency. Software can ask for a background re-initialisation of one
// task's 8 entries with a level req / one-cycle done handshake.
//
// Every entry takes three cycles so that address and data are stable for a
// full cycle on both sides of the write strobe:
//   SETUP  : address/data driven, MMU_nWR high
//   STROBE : MMU_nWR low
//   HOLD   : MMU_nWR high, address/data still held
//
// Ports
//   CLKX4      in   system clock, rising edge
//   nRESET     in   asynchronous active-low reset
//   cpu_addr   in   [7:0] MMU RAM address from the mmu block, {task, slot}
//   cpu_nrd    in   MMU RAM read strobe, active low
//   cpu_nwr    in   MMU RAM write strobe, active low
//   cpu_wdata  in   [7:0] MMU RAM write data
//   req        in   level request to re-initialise task req_task
//   req_task   in   [4:0] task number, sampled on the accept edge
//   MMU_ADDR   out  [7:0] physical RAM address
//   MMU_nRD    out  physical RAM output enable, active low
//   MMU_nWR    out  physical RAM write strobe, active low
//   MMU_DOUT   out  [7:0] data driven to the RAM
//   MMU_DOE    out  drive enable for MMU_DOUT onto the RAM data bus
//   busy       out  a sequence (full or task) is running
//   nHALT      out  CPU halt, low only during the post-reset full init
//   done       out  one-cycle pulse as a task re-initialisation completes
// ============================================================================
module mmu_ram_seq #(
   parameter logic [1:0] RAM_CS = 2'b10,   // chip select for slots 0-3
   parameter logic [1:0] ROM_CS = 2'b00    // chip select for slots 4-7
) (
   input  logic       CLKX4,
   input  logic       nRESET,
   input  logic [7:0] cpu_addr,
   input  logic       cpu_nrd,
   input  logic       cpu_nwr,
   input  logic [7:0] cpu_wdata,
   input  logic       req,
   input  logic [4:0] req_task,
   output logic [7:0] MMU_ADDR,
   output logic       MMU_nRD,
   output logic       MMU_nWR,
   output logic [7:0] MMU_DOUT,
   output logic       MMU_DOE,
   output logic       busy,
   output logic       nHALT,
   output logic       done
);

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
   typedef enum logic       {MODE_FULL, MODE_TASK}      mode_t;

   state_t     state, state_nxt;
   mode_t      mode,  mode_nxt;
   logic [7:0] ptr,   ptr_nxt;
   logic       armed, armed_nxt;

   logic       last;
   logic       accept;
   logic [7:0] def_val;

   // Default map entry: depends only on the slot, identical for every task.
   assign def_val = {(ptr[2] ? ROM_CS : RAM_CS), 3'b000, ptr[2:0]};

   // FULL ends after entry FF; TASK ends after slot 7 of its task, so a task
   // sequence on task 31 stops at FF and never wraps.
   assign last   = (mode == MODE_FULL) ? (ptr == 8'hFF) : (ptr[2:0] == 3'b111);

   // A CPU write in flight defers the accept; armed makes a held req fire once.
   assign accept = (state == IDLE) && req && armed && cpu_nwr;

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         state <= SETUP;
         mode  <= MODE_FULL;
         ptr   <= 8'h00;
         armed <= 1'b1;
      end else begin
         state <= state_nxt;
         mode  <= mode_nxt;
         ptr   <= ptr_nxt;
         armed <= armed_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode;
      ptr_nxt   = ptr;
      armed_nxt = armed;

      // Any cycle with req low re-arms the request handshake.
      if (!req)
         armed_nxt = 1'b1;

      unique case (state)
         IDLE: begin
            if (accept) begin
               mode_nxt  = MODE_TASK;
               ptr_nxt   = {req_task, 3'b000};
               armed_nxt = 1'b0;
               state_nxt = SETUP;
            end
         end
         SETUP:  state_nxt = STROBE;
         STROBE: state_nxt = HOLD;
         HOLD: begin
            if (last) begin
               state_nxt = IDLE;
            end else begin
               ptr_nxt   = ptr + 8'd1;
               state_nxt = SETUP;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // Reset leaves the FSM parked in SETUP of entry 0, which would otherwise
   // drive the entry-0 default onto the bus. Data and drive enable are gated
   // with nRESET so the bus is quiet while reset is held, and the first
   // SETUP cycle after release still drives the entry normally.
   always_comb begin
      MMU_ADDR = ptr;
      MMU_nRD  = 1'b1;
      MMU_nWR  = 1'b1;
      MMU_DOUT = 8'h00;
      MMU_DOE  = 1'b0;

      if (state == IDLE) begin
         // Straight combinational passthrough of the mmu block's port.
         MMU_ADDR = cpu_addr;
         MMU_nRD  = cpu_nrd;
         MMU_nWR  = cpu_nwr;
         MMU_DOUT = cpu_wdata;
         MMU_DOE  = !cpu_nwr;
      end else begin
         MMU_ADDR = ptr;
         MMU_nWR  = (state != STROBE);
         MMU_DOUT = nRESET ? def_val : 8'h00;
         MMU_DOE  = nRESET;
      end
   end

   assign busy  = (state != IDLE);
   assign nHALT = !(busy && (mode == MODE_FULL));
   assign done  = (state == HOLD) && (mode == MODE_TASK) && last;

endmodule

// File: tb/tb_mmu_ram_seq.sv
// Bench for mmu_ram_seq: models the physical RAM, watches each sequence
// and compares against values derived from the default-map rule and the
// published cycle counts.
module tb_mmu_ram_seq;

   logic       CLKX4 = 1'b0;
   logic       nRESET;
   logic [7:0] cpu_addr;
   logic       cpu_nrd;
   logic       cpu_nwr;
   logic [7:0] cpu_wdata;
   logic       req;
   logic [4:0] req_task;
   logic [7:0] MMU_ADDR;
   logic       MMU_nRD;
   logic       MMU_nWR;
   logic [7:0] MMU_DOUT;
   logic       MMU_DOE;
   logic       busy;
   logic       nHALT;
   logic       done;

   mmu_ram_seq dut (
      .CLKX4(CLKX4), .nRESET(nRESET),
      .cpu_addr(cpu_addr), .cpu_nrd(cpu_nrd), .cpu_nwr(cpu_nwr),
      .cpu_wdata(cpu_wdata), .req(req), .req_task(req_task),
      .MMU_ADDR(MMU_ADDR), .MMU_nRD(MMU_nRD), .MMU_nWR(MMU_nWR),
      .MMU_DOUT(MMU_DOUT), .MMU_DOE(MMU_DOE),
      .busy(busy), .nHALT(nHALT), .done(done)
   );

   always #5 CLKX4 = ~CLKX4;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Physical RAM model: writes land on the rising edge while the strobe is low.
   logic [7:0] ram [256];
   always @(posedge CLKX4)
      if (!MMU_nWR && MMU_DOE) ram[MMU_ADDR] <= MMU_DOUT;

   // Reference default entry: slots 0-3 -> RAM select (8'h80 | s), 4-7 -> s.
   function automatic logic [7:0] exp_def(input int e);
      int s;
      s = e % 8;
      return (s < 4) ? (8'h80 | 8'(s)) : 8'(s);
   endfunction

   // Strobe-stability monitor: address/data must match one sample before and
   // after each sequencer write cycle.
   logic [2:0][7:0] ha, hd;
   logic [2:0]      hw = 3'b111;
   logic [2:0]      hv = 3'b000;
   int stab_err = 0;
   always @(negedge CLKX4) begin
      ha = {ha[1:0], MMU_ADDR};
      hd = {hd[1:0], MMU_DOUT};
      hw = {hw[1:0], MMU_nWR};
      hv = {hv[1:0], nRESET && busy};
      if (hv == 3'b111 && !hw[1])
         if (ha[0] != ha[1] || ha[2] != ha[1] || hd[0] != hd[1] || hd[2] != hd[1])
            stab_err++;
   end

   // Sequence watcher results
   int w_busy, w_nhl, w_nwr, w_done, w_done_at, w_lo, w_hi;

   task automatic watch(input int maxc);
      int n;
      n = 0; w_busy = 0; w_nhl = 0; w_nwr = 0; w_done = 0; w_done_at = 0;
      w_lo = 999; w_hi = -1;
      do begin
         @(negedge CLKX4);
         n++;
         if (busy) w_busy++;
         if (!nHALT) w_nhl++;
         if (!MMU_nWR && busy) begin
            w_nwr++;
            if (int'(MMU_ADDR) < w_lo) w_lo = int'(MMU_ADDR);
            if (int'(MMU_ADDR) > w_hi) w_hi = int'(MMU_ADDR);
         end
         if (done) begin w_done++; w_done_at = n; end
      end while (busy && n < maxc);
      if (busy) chk("watch_timeout", 1, 0);
   endtask

   task automatic tick;
      @(posedge CLKX4);
      #1;
   endtask

   task automatic chk_rst(input string p);
      chk({p, "_addr"},  MMU_ADDR, 0);
      chk({p, "_dout"},  MMU_DOUT, 0);
      chk({p, "_doe"},   MMU_DOE, 0);
      chk({p, "_nwr"},   MMU_nWR, 1);
      chk({p, "_nrd"},   MMU_nRD, 1);
      chk({p, "_busy"},  busy, 1);
      chk({p, "_nhalt"}, nHALT, 0);
      chk({p, "_done"},  done, 0);
   endtask

   task automatic chk_full_init(input string p);
      int errs;
      chk({p, "_busy_cyc"}, w_busy, 768);
      chk({p, "_halt_cyc"}, w_nhl, 768);
      chk({p, "_nwr_cnt"},  w_nwr, 256);
      chk({p, "_done_cnt"}, w_done, 0);
      chk({p, "_nhalt_up"}, nHALT, 1);
      errs = 0;
      for (int e = 0; e < 256; e++) if (ram[e] !== exp_def(e)) errs++;
      chk({p, "_map_errs"}, errs, 0);
   endtask

   task automatic cpu_write(input int a, input logic [7:0] d);
      cpu_addr = 8'(a); cpu_wdata = d; cpu_nwr = 1'b0;
      tick;
      cpu_nwr = 1'b1;
   endtask

   task automatic do_task(input int t);
      int base, nb, errs;
      base = t * 8;
      nb   = (t > 0) ? base - 1 : base + 8;
      for (int k = 0; k < 8; k++) cpu_write(base + k, 8'hFF);
      cpu_write(nb, 8'hFF);
      req = 1'b1; req_task = 5'(t);
      tick;
      req = 1'b0; req_task = 5'($urandom);   // must be ignored after accept
      watch(200);
      chk("task_busy_cyc", w_busy, 24);
      chk("task_done_cnt", w_done, 1);
      chk("task_done_at",  w_done_at, 24);
      chk("task_halt",     w_nhl, 0);
      chk("task_nwr_cnt",  w_nwr, 8);
      chk("task_lo",       w_lo, base);
      chk("task_hi",       w_hi, base + 7);
      tick;
      errs = 0;
      for (int k = 0; k < 8; k++) if (ram[base + k] !== exp_def(base + k)) errs++;
      chk("task_map_errs", errs, 0);
      chk("task_neighbour", ram[nb], 8'hFF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      for (int e = 0; e < 256; e++) ram[e] = 8'h00;
      nRESET = 1'b0; cpu_addr = 8'h00; cpu_nrd = 1'b1; cpu_nwr = 1'b1;
      cpu_wdata = 8'h00; req = 1'b0; req_task = 5'd0;

      // Reset values and full init
      repeat (3) tick;
      chk_rst("rst");
      nRESET = 1'b1;
      watch(2000);
      chk_full_init("init");
      chk("init_lo", w_lo, 0);
      chk("init_hi", w_hi, 255);
      chk("init_e05", ram[5], 8'h05);
      chk("init_e02", ram[2], 8'h82);

      // Idle passthrough, combinational
      tick;
      for (int i = 0; i < 16; i++) begin
         if (i == 0) begin
            cpu_addr = 8'h3A; cpu_nwr = 1'b0; cpu_wdata = 8'hC4; cpu_nrd = 1'b1;
         end else begin
            cpu_addr = 8'($urandom); cpu_nwr = 1'($urandom);
            cpu_wdata = 8'($urandom); cpu_nrd = 1'($urandom);
         end
         #1;
         chk("pt_addr", MMU_ADDR, cpu_addr);
         chk("pt_nwr",  MMU_nWR, cpu_nwr);
         chk("pt_nrd",  MMU_nRD, cpu_nrd);
         chk("pt_dout", MMU_DOUT, cpu_wdata);
         chk("pt_doe",  MMU_DOE, !cpu_nwr);
         tick;
      end
      cpu_nwr = 1'b1; cpu_nrd = 1'b1;
      tick;

      // Task re-initialisation: fixed corners plus random tasks
      do_task(9);
      do_task(31);
      do_task(0);
      for (int i = 0; i < 3; i++) do_task(int'($urandom_range(0, 31)));

      // Held req fires exactly once
      tick;
      req = 1'b1; req_task = 5'($urandom_range(0, 31));
      w_busy = 0; w_done = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLKX4);
         if (busy) w_busy++;
         if (done) w_done++;
      end
      chk("held_busy_cyc", w_busy, 24);
      chk("held_done_cnt", w_done, 1);
      tick;
      req = 1'b0;
      tick;
      req = 1'b1;
      tick;
      watch(100);
      chk("rearm_busy_cyc", w_busy, 24);
      chk("rearm_done_cnt", w_done, 1);
      req = 1'b0;

      // Deferred accept behind a CPU write
      tick;
      cpu_addr = 8'h10; cpu_wdata = 8'($urandom); cpu_nwr = 1'b0;
      req = 1'b1; req_task = 5'd5;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLKX4);
         chk("defer_busy", busy, 0);
         chk("defer_addr", MMU_ADDR, 8'h10);
         tick;
      end
      cpu_nwr = 1'b1;
      @(negedge CLKX4);
      chk("defer_pre_accept", busy, 0);
      tick;
      req = 1'b0;
      watch(100);
      chk("defer_busy_cyc", w_busy, 24);
      chk("defer_done_cnt", w_done, 1);
      chk("defer_lo", w_lo, 8'h28);

      // Reset in the middle of a task-31 sequence
      tick;
      req = 1'b1; req_task = 5'd31;
      tick;
      req = 1'b0;
      dc = 0;
      repeat (10) begin
         @(negedge CLKX4);
         if (done) dc++;
      end
      #1 nRESET = 1'b0;
      #1 chk_rst("midrst");
      chk("midrst_done_cnt", dc, 0);
      tick;
      tick;
      nRESET = 1'b1;
      watch(2000);
      chk_full_init("reinit");

      chk("strobe_stability", stab_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmu_ram_seq.md
# mmu_ram_seq

Sequencer for the external 256x8 MMU mapping RAM. After reset it walks all 256 entries and writes a default identity map while holding the CPU halted, then passes CPU-side MMU RAM accesses straight through. Software can also request a background re-initialisation of one task's 8 entries via a req/done handshake. It sits between the mmu block's MMU RAM port and the physical RAM.

## Interface
- RAM_CS, 2'b10, chip-select code written for slots 0-3 (lower 32K).
- ROM_CS, 2'b00, chip-select code written for slots 4-7 (upper 32K).
- CLKX4  in  1  system clock, all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- cpu_addr  in  8  MMU RAM address from the mmu block, {task, slot}.
- cpu_nrd  in  1  MMU RAM read strobe from the mmu block, active low.
- cpu_nwr  in  1  MMU RAM write strobe from the mmu block, active low.
- cpu_wdata  in  8  MMU RAM write data from the mmu block.
- req  in  1  level request: re-initialise task req_task.
- req_task  in  5  task number to re-initialise, sampled on accept.
- MMU_ADDR  out  8  physical MMU RAM address.
- MMU_nRD  out  1  physical RAM output enable, active low.
- MMU_nWR  out  1  physical RAM write strobe, active low.
- MMU_DOUT  out  8  data driven to the RAM.
- MMU_DOE  out  1  drive enable for MMU_DOUT onto MMU_DATA.
- busy  out  1  high while a sequence is running.
- nHALT  out  1  CPU halt, low during the full post-reset init only.
- done  out  1  one-cycle pulse when a task re-initialisation completes.

## Operation
- Default entry value for slot s = e[2:0]: s<4 -> {RAM_CS, 3'b000, s}; s>=4 -> {ROM_CS, 3'b000, s}. The value is the same for every task.
- States: IDLE, SETUP, STROBE, HOLD. A 1-bit mode register selects FULL or TASK. An 8-bit pointer ptr tracks the current entry.
- Each entry takes three cycles:
  - SETUP: MMU_ADDR=ptr, MMU_DOUT=default(ptr), MMU_DOE=1, MMU_nWR=1.
  - STROBE: MMU_nWR=0, address and data held.
  - HOLD: MMU_nWR=1, address and data held.
- After HOLD, if ptr is the last entry (FULL: ptr==8'hFF; TASK: ptr[2:0]==3'b111), go to IDLE. Otherwise ptr increments and the state returns to SETUP.
- Reset: state=SETUP, mode=FULL, ptr=0.
- IDLE passthrough:
  - MMU_ADDR=cpu_addr, MMU_nRD=cpu_nrd, MMU_nWR=cpu_nwr, MMU_DOUT=cpu_wdata, MMU_DOE=!cpu_nwr.
  - These are combinational, with no added latency.
- Outside IDLE, MMU_nRD=1 and all cpu_* inputs are ignored. CPU writes issued during a TASK sequence are lost; software must poll busy.
- Accepting a request:
  - Accept only in IDLE with req=1, the armed flag set, and cpu_nwr=1.
  - On accept: mode=TASK, ptr={req_task,3'b000}, armed cleared, go to SETUP.
  - armed sets on any cycle with req=0. A held req therefore triggers exactly one sequence.
- done pulses for one cycle on the HOLD->IDLE transition in TASK mode only. It never pulses after a FULL init.
- busy = (state!=IDLE). nHALT = !(busy && mode==FULL).

## Timing
- Reset values of every output: MMU_ADDR=0, MMU_DOUT=0, MMU_DOE=0, MMU_nWR=1, MMU_nRD=1, busy=1, nHALT=0, done=0. armed resets to 1.
- Full init takes 768 cycles from reset release. MMU_nWR pulses low exactly 256 times. nHALT rises on cycle 769, together with entry to IDLE.
- TASK sequence takes 24 cycles from the accept edge to IDLE. done is high in the 24th cycle after accept.
- Address and data are stable for one full cycle before and after every low MMU_nWR cycle.
- If a CPU write is in progress (cpu_nwr=0) while req=1, the accept is deferred until cpu_nwr returns high.
- If nRESET is asserted mid-sequence (FULL or TASK), the sequencer returns to the reset state. A full init restarts on release, and no done pulse is produced.
- req_task is sampled only on the accept edge; later changes are ignored.
- ptr wraps only via a state change. A TASK sequence on task 31 ends at entry 8'hFF and never wraps to 0.

## Test plan
- Reset release: count MMU_nWR low pulses -> exactly 256.
  - Entry 8'h05 written with 8'h05 (ROM_CS), entry 8'h02 with 8'h82.
  - nHALT low for 768 cycles, then high; done never pulses.
- Idle passthrough: cpu_addr=8'h3A, cpu_nwr=0, cpu_wdata=8'hC4 -> same cycle MMU_ADDR=8'h3A, MMU_nWR=0, MMU_DOUT=8'hC4, MMU_DOE=1.
- Task clear: preload entries 8'h48-8'h4F with 8'hFF, pulse req with req_task=9.
  - Those 8 entries are restored to defaults and entry 8'h47 is untouched.
  - busy is high for 24 cycles, done pulses once, nHALT stays high.
- Held req: keep req=1 for 100 cycles -> exactly one sequence and one done pulse.
  - Drop req for one cycle and raise it again -> a second sequence runs.
- Deferred accept: req=1 while cpu_nwr=0 for 3 cycles -> no MMU_nWR from the sequencer until cpu_nwr rises; the accept happens on the following edge.
- Reset mid-task: assert nRESET at cycle 10 of a task=31 sequence -> all outputs return to reset values, a full 768-cycle init follows, and no done pulse occurs.
